// File: rtl/compressor.sv
// compressor
//
// Zero-run bit-packing encoder. Each DATA_W-bit input element becomes a
// 1-bit '0' code when it is zero, or a '1' flag followed by the element
// value otherwise. Codes are packed MSB-first into 64-bit words (bit 63 is
// the first bit of the stream). A flush drains the final partial word,
// zero-padded, with out_nbits giving its valid bit count.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   in_valid   in_data holds an element
//   in_data    element value (DATA_W bits, the element width n)
//   in_ready   element accepted when in_valid && in_ready
//   flush      end-of-stream request, sampled only when in_ready
//   out_valid  out_data holds a packed word
//   out_data   packed 64-bit word, MSB first
//   out_ready  word consumed when out_valid && out_ready
//   out_last   current word is the final word of the stream
//   out_nbits  valid bits in the current word (64, or 1..63 when out_last)
//   done       one-cycle pulse when a flush has completed
module compressor #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              flush,
  output logic              out_valid,
  output logic [63:0]       out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic [6:0]        out_nbits,
  output logic              done
);

  localparam int CODE_W = DATA_W + 1;
  localparam int ACC_W  = 64 + CODE_W;

  typedef enum logic [1:0] {RUN, FLUSH, LAST, DONE} state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ACC_W-1:0]   acc_q;
  logic [6:0]         fill_q;
  logic               accept;
  logic               out_free;
  logic               do_emit;
  logic               do_last;
  logic               do_finish;

  // Place a nonzero element's {1, value} code starting pos bits below the
  // accumulator MSB. Bits under the fill point are always zero, so an OR
  // is enough to append.
  function automatic logic [ACC_W-1:0] place_code(input logic [DATA_W-1:0] d,
                                                  input logic [6:0]        pos);
    logic [ACC_W-1:0] code;
    code = {1'b1, d, 64'd0};
    return code >> pos;
  endfunction

  // in_ready depends only on registered state, so an accept (fill < 64)
  // and an emit (fill >= 64) can never coincide.
  assign in_ready = (state_q == RUN) && (fill_q < 7'd64);
  assign accept   = in_valid && in_ready;
  assign out_free = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    do_emit   = 1'b0;
    do_last   = 1'b0;
    do_finish = 1'b0;
    case (state_q)
      RUN: begin
        do_emit = (fill_q >= 7'd64) && out_free;
        if (in_ready && flush) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (fill_q >= 7'd64) begin
          do_emit = out_free;
        end else if (fill_q != 7'd0) begin
          state_d = LAST;
        end else begin
          state_d = DONE;
        end
      end
      LAST: begin
        if (out_free) begin
          do_last = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        // Hold off the done pulse until the final word has left.
        if (out_free) begin
          do_finish = 1'b1;
          state_d   = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Stage boundary: accumulator append/shift and output word register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q     <= '0;
      fill_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_nbits <= '0;
      done      <= 1'b0;
    end else begin
      done <= do_finish;

      if (accept) begin
        if (in_data != '0) begin
          acc_q  <= acc_q | place_code(in_data, fill_q);
          fill_q <= fill_q + 7'(CODE_W);
        end else begin
          fill_q <= fill_q + 7'd1;
        end
      end else if (do_emit) begin
        acc_q  <= acc_q << 64;
        fill_q <= fill_q - 7'd64;
      end else if (do_last) begin
        fill_q <= '0;
      end else if (do_finish) begin
        acc_q <= '0;
      end

      if (do_emit) begin
        out_valid <= 1'b1;
        out_data  <= acc_q[ACC_W-1 -: 64];
        out_nbits <= 7'd64;
        out_last  <= 1'b0;
      end else if (do_last) begin
        out_valid <= 1'b1;
        out_data  <= acc_q[ACC_W-1 -: 64];
        out_nbits <= fill_q;
        out_last  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
